// File: rtl/imem_pipe.sv
// Byte-addressed instruction memory behind a valid/ready fetch pipe.
// Four consecutive bytes are assembled little-endian into a 32-bit word.
//   state  | meaning
//   S_IDLE | no response held, ready for a request
//   S_WAIT | request latched, counting down the programmed read latency
//   S_RESP | response registered and presented until rsp_ready
module imem_pipe #(
  parameter int unsigned DEPTH_BYTES = 65536,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned WAIT_CYCLES = 0,
  parameter bit          OOR_MODE    = 1'b1,
  parameter bit          ALIGN_CHECK = 1'b1,
  parameter string       INIT_FILE   = "data/imemfile.dat"
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_inst,
  output logic        rsp_err,
  input  logic        ld_we,
  input  logic [31:0] ld_addr,
  input  logic [7:0]  ld_data
);

  localparam int unsigned AW       = $clog2(DEPTH_BYTES);
  localparam logic [31:0] LAST_OFF = 32'(DEPTH_BYTES - 4);
  localparam logic [3:0]  WAIT_N   = 4'(WAIT_CYCLES);
  localparam logic [31:0] NOP      = 32'h0000_0013;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  logic [7:0]  mem [DEPTH_BYTES];

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] rsp_inst_q, rsp_inst_d;
  logic        rsp_err_q, rsp_err_d;

  logic          accept;
  logic          sample;
  logic [31:0]   rd_addr;
  logic [31:0]   rd_off;
  logic          rd_err;
  logic [31:0]   rd_word;
  logic [AW-1:0] ld_idx;

  assign req_ready = (state_q == S_IDLE) || ((state_q == S_RESP) && rsp_ready);
  assign accept    = req_valid && req_ready;

  // Zero-latency reads sample the incoming address; otherwise the latched one.
  assign rd_addr = (state_q == S_WAIT) ? addr_q : req_addr;

  always_comb begin
    rd_word = '0;
    rd_off  = rd_addr - BASE_ADDR;
    rd_err  = (ALIGN_CHECK && (rd_addr[1:0] != 2'b00)) ||
              (OOR_MODE && (rd_off > LAST_OFF));
    for (int k = 0; k < 4; k++) begin
      rd_word[8*k +: 8] = mem[rd_off[AW-1:0] + AW'(k)];
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    rsp_valid_d = rsp_valid_q;
    rsp_inst_d  = rsp_inst_q;
    rsp_err_d   = rsp_err_q;
    sample      = 1'b0;
    case (state_q)
      S_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = S_RESP;
          sample  = 1'b1;
        end
      end
      default: begin
        if ((state_q == S_RESP) && rsp_ready) begin
          state_d     = S_IDLE;
          rsp_valid_d = 1'b0;
        end
        if (accept) begin
          addr_d = req_addr;
          cnt_d  = WAIT_N;
          if (WAIT_N == 4'd0) begin
            state_d = S_RESP;
            sample  = 1'b1;
          end else begin
            state_d = S_WAIT;
          end
        end
      end
    endcase
    if (sample) begin
      rsp_valid_d = 1'b1;
      rsp_err_d   = rd_err;
      rsp_inst_d  = rd_err ? NOP : rd_word;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      addr_q      <= '0;
      rsp_valid_q <= 1'b0;
      rsp_inst_q  <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_inst_q  <= rsp_inst_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  // Loader always wraps; the read above sees the pre-edge contents.
  assign ld_idx = AW'(ld_addr - BASE_ADDR);

  always_ff @(posedge clk) begin
    if (ld_we) mem[ld_idx] <= ld_data;
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_inst  = rsp_inst_q;
  assign rsp_err   = rsp_err_q;

endmodule
